// File: rtl/dds_key_pkg.sv
// Shared constants and types for the DDS key controller: frequency table, phase step,
// key indices and the debounce FSM state type.
package dds_key_pkg;

    localparam int NumKeys   = 4;
    localparam int KeyFreqA  = 0;
    localparam int KeyFreqB  = 1;
    localparam int KeyPhaseB = 2;
    localparam int KeyReset  = 3;

    // Tuning words for a 32-bit phase accumulator clocked at 50 MHz.
    localparam logic [31:0] FreqWord1k   = 32'd85_899;
    localparam logic [31:0] FreqWord10k  = 32'd858_993;
    localparam logic [31:0] FreqWord100k = 32'd8_589_935;
    localparam logic [31:0] FreqWord1M   = 32'd85_899_346;

    localparam logic [11:0] PhaseStep = 12'd1024;

    typedef enum logic [1:0] {
        StIdle,
        StPressFilt,
        StDown,
        StRelFilt
    } deb_state_e;

    function automatic logic [31:0] freq_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return FreqWord1k;
            2'd1:    return FreqWord10k;
            2'd2:    return FreqWord100k;
            default: return FreqWord1M;
        endcase
    endfunction

endpackage

// File: rtl/dds_key_if.sv
// Key inputs and DDS control words between the key controller and its consumer.
interface dds_key_if;

    logic [3:0]  key;
    logic [31:0] fwordA;
    logic [31:0] fwordB;
    logic [11:0] pwordA;
    logic [11:0] pwordB;
    logic [1:0]  freq_selA;
    logic [1:0]  freq_selB;
    logic        cfg_update;

    modport master (
        input  key,
        output fwordA,
        output fwordB,
        output pwordA,
        output pwordB,
        output freq_selA,
        output freq_selB,
        output cfg_update
    );

    modport slave (
        output key,
        input  fwordA,
        input  fwordB,
        input  pwordA,
        input  pwordB,
        input  freq_selA,
        input  freq_selB,
        input  cfg_update
    );

endinterface

// File: rtl/dds_key_filter.sv
// Synchronizer plus debounce FSM for one active-low key; emits a one-cycle press pulse.
// Auto-repeat while held is built only when DDS_KEY_AUTOREPEAT_EN is defined.
module dds_key_filter
    import dds_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 1_000_000
`ifdef DDS_KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_CNT   = 25_000_000,
    parameter bit          REPEAT_EN    = 1'b1
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT - 1);

    logic [1:0]      sync_q;
    logic            key_s;
    deb_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            press_q;

    // Reset to 1 so a reset never looks like a key going down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    assign key_s = sync_q[1];

`ifdef DDS_KEY_AUTOREPEAT_EN
    localparam int unsigned RepW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
    localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_CNT - 1);

    logic [RepW-1:0] rep_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            press_q <= 1'b0;
`ifdef DDS_KEY_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            press_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!key_s) begin
                        state_q <= StPressFilt;
                        cnt_q   <= '0;
                    end
                end
                StPressFilt: begin
                    if (key_s) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StDown;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
`ifdef DDS_KEY_AUTOREPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDown: begin
                    if (key_s) begin
                        state_q <= StRelFilt;
                        cnt_q   <= '0;
                    end
`ifdef DDS_KEY_AUTOREPEAT_EN
                    else if (REPEAT_EN) begin
                        if (rep_q == RepMax) begin
                            press_q <= 1'b1;
                            rep_q   <= '0;
                        end else begin
                            rep_q <= rep_q + 1'b1;
                        end
                    end
`endif
                end
                StRelFilt: begin
                    if (!key_s) begin
                        // Bounce during release: back to held, repeat period restarts.
                        state_q <= StDown;
                        cnt_q   <= '0;
`ifdef DDS_KEY_AUTOREPEAT_EN
                        rep_q   <= '0;
`endif
                    end else if (cnt_q == CntMax) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dds_key_ctrl.sv
// Four debounced push-buttons driving DDS frequency/phase control words for two channels.
// Optional feature macro: DDS_KEY_AUTOREPEAT_EN (auto-repeat on held keys 0..2).
module dds_key_ctrl
    import dds_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 1_000_000,
    parameter int unsigned REPEAT_CNT   = 25_000_000
) (
    input  logic      clk,
    input  logic      reset_n,
    dds_key_if.master bus
);

    if (DEBOUNCE_CNT == 0 || REPEAT_CNT == 0) begin : g_bad_param
        $error("dds_key_ctrl: DEBOUNCE_CNT and REPEAT_CNT must be nonzero");
    end

    logic [NumKeys-1:0] press;

    for (genvar i = 0; i < NumKeys; i++) begin : g_filter
        dds_key_filter #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
`ifdef DDS_KEY_AUTOREPEAT_EN
            ,
            .REPEAT_CNT  (REPEAT_CNT),
            .REPEAT_EN   (i != KeyReset)
`endif
        ) u_filter (
            .clk    (clk),
            .reset_n(reset_n),
            .key_raw(bus.key[i]),
            .press  (press[i])
        );
    end

    logic [1:0]  sel_a_q;
    logic [1:0]  sel_b_q;
    logic [31:0] fword_a_q;
    logic [31:0] fword_b_q;
    logic [11:0] pword_b_q;
    logic        cfg_update_q;

    // Reset key wins outright; the other three may all land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_a_q      <= 2'd0;
            sel_b_q      <= 2'd0;
            fword_a_q    <= FreqWord1k;
            fword_b_q    <= FreqWord1k;
            pword_b_q    <= 12'd0;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            if (press[KeyReset]) begin
                sel_a_q      <= 2'd0;
                sel_b_q      <= 2'd0;
                fword_a_q    <= FreqWord1k;
                fword_b_q    <= FreqWord1k;
                pword_b_q    <= 12'd0;
                cfg_update_q <= 1'b1;
            end else if (|press[KeyPhaseB:KeyFreqA]) begin
                cfg_update_q <= 1'b1;
                if (press[KeyFreqA]) begin
                    sel_a_q   <= sel_a_q + 2'd1;
                    fword_a_q <= freq_word(sel_a_q + 2'd1);
                end
                if (press[KeyFreqB]) begin
                    sel_b_q   <= sel_b_q + 2'd1;
                    fword_b_q <= freq_word(sel_b_q + 2'd1);
                end
                if (press[KeyPhaseB]) begin
                    pword_b_q <= pword_b_q + PhaseStep;
                end
            end
        end
    end

    assign bus.fwordA     = fword_a_q;
    assign bus.fwordB     = fword_b_q;
    assign bus.pwordA     = 12'd0;
    assign bus.pwordB     = pword_b_q;
    assign bus.freq_selA  = sel_a_q;
    assign bus.freq_selB  = sel_b_q;
    assign bus.cfg_update = cfg_update_q;

endmodule
